// File: rtl/gate_function_identifier.sv
// gate_function_identifier
// Watches (a, b, y) samples from an unknown 2-input gate and fills in a
// 4-entry truth table indexed by {a,b}. When the table is full, or a
// contradiction appears, or the sample budget runs out, it reports which gate
// produced the samples.
// Samples come in over a valid/ready handshake, and the result goes out over
// another valid/ready handshake.

module gate_function_identifier #(
   parameter int MAX_SAMPLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_a,
   input  logic       in_b,
   input  logic       in_y,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [2:0] res_code,
   output logic       res_conflict,
   output logic       res_incomplete,
   output logic       busy
);

   localparam int CW = $clog2(MAX_SAMPLES + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_SAMPLES);

   localparam logic [2:0] CODE_AND     = 3'd0;
   localparam logic [2:0] CODE_OR      = 3'd1;
   localparam logic [2:0] CODE_NAND    = 3'd2;
   localparam logic [2:0] CODE_NOR     = 3'd3;
   localparam logic [2:0] CODE_XOR     = 3'd4;
   localparam logic [2:0] CODE_XNOR    = 3'd5;
   localparam logic [2:0] CODE_NOT_A   = 3'd6;
   localparam logic [2:0] CODE_UNKNOWN = 3'd7;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      REPORT  = 2'd2
   } state_t;

   state_t state, next_state;

   logic [3:0]    t, seen;
   logic [CW-1:0] count;

   logic [2:0] res_code_q;
   logic       res_conflict_q;
   logic       res_incomplete_q;

   logic          accept;
   logic [1:0]    idx;
   logic          hit_conflict;
   logic [3:0]    t_nxt;
   logic [3:0]    seen_nxt;
   logic [CW-1:0] count_nxt;
   logic          reached_max;
   logic          now_incomplete;
   logic          finish;

   // Map a completed truth table t[3:0] (bit index = {a,b}) onto a gate code.
   function automatic logic [2:0] match_code(input logic [3:0] tt);
      logic [2:0] c;
      case (tt)
         4'b1000: c = CODE_AND;
         4'b1110: c = CODE_OR;
         4'b0111: c = CODE_NAND;
         4'b0001: c = CODE_NOR;
         4'b0110: c = CODE_XOR;
         4'b1001: c = CODE_XNOR;
         4'b0011: c = CODE_NOT_A;
         default: c = CODE_UNKNOWN;
      endcase
      return c;
   endfunction

   assign in_ready       = (state == COLLECT);
   assign res_valid      = (state == REPORT);
   assign busy           = (state != IDLE);
   assign res_code       = res_code_q;
   assign res_conflict   = res_conflict_q;
   assign res_incomplete = res_incomplete_q;

   // Work out what the current sample would do to the table, and choose the next FSM state.
   always_comb begin
      next_state     = state;
      accept         = in_valid && in_ready;
      idx            = {in_a, in_b};
      hit_conflict   = seen[idx] && (t[idx] != in_y);
      t_nxt          = t;
      seen_nxt       = seen;
      if (!hit_conflict) begin
         t_nxt[idx]    = in_y;
         seen_nxt[idx] = 1'b1;
      end
      count_nxt      = count + 1'b1;
      reached_max    = (count_nxt == MAX_CNT);
      now_incomplete = reached_max && (seen_nxt != 4'b1111);
      finish         = accept && ((seen_nxt == 4'b1111) || hit_conflict || reached_max);

      case (state)
         IDLE:    if (start)     next_state = COLLECT;
         COLLECT: if (finish)    next_state = REPORT;
         REPORT:  if (res_ready) next_state = IDLE;
         default:                next_state = IDLE;
      endcase
   end

   // State register. Reset aborts any run in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Truth table, seen mask, sample count and the registered result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t                <= '0;
         seen             <= '0;
         count            <= '0;
         res_code_q       <= '0;
         res_conflict_q   <= 1'b0;
         res_incomplete_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  t                <= '0;
                  seen             <= '0;
                  count            <= '0;
                  res_code_q       <= '0;
                  res_conflict_q   <= 1'b0;
                  res_incomplete_q <= 1'b0;
               end
            end
            COLLECT: begin
               if (accept) begin
                  t     <= t_nxt;
                  seen  <= seen_nxt;
                  count <= count_nxt;
                  if (finish) begin
                     res_conflict_q   <= hit_conflict;
                     res_incomplete_q <= now_incomplete;
                     res_code_q       <= (hit_conflict || now_incomplete) ? CODE_UNKNOWN
                                                                          : match_code(t_nxt);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
